data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache on the cpu data port.
//  Decodes the cpu load/store enables and returns load data with byte/half sign handling.
//  Stalls the pipeline through DATA_CACHE_BUSY_WAIT on a miss.
//  Refills and evicts 128-bit blocks from main memory through a block-level busy-wait interface.
// PARAMETERS
//  INDEX_BITS  3  line index width; NUM_LINES = 2**INDEX_BITS; tag = 28-INDEX_BITS bits
// PORTS
//  CLK                   in   1    clock, all state updates on posedge
//  RESET                 in   1    asynchronous, active-high reset
//  memReadEn             in   4    [3]=load enable, [2:0]=funct3 (000 LB,001 LH,010 LW,100 LBU,101 LHU)
//  memWriteEn            in   3    [2]=store enable, [1:0]=funct3[1:0] (00 SB,01 SH,10 SW)
//  DATA_CACHE_ADDR       in   32   byte address from cpu
//  DATA_CACHE_DATA       in   32   store data; SB uses [7:0], SH uses [15:0]
//  DATA_CACHE_READ_DATA  out  32   load result, sign/zero extended
//  DATA_CACHE_BUSY_WAIT  out  1    cpu must hold request and stall while high
//  MEM_READ              out  1    block read request to memory
//  MEM_WRITE             out  1    block write request to memory
//  MEM_ADDR              out  28   block address (byte address [31:4])
//  MEM_WRITE_DATA        out  128  evicted block, word0 in [31:0]
//  MEM_READ_DATA         in   128  refill block, word0 in [31:0]
//  MEM_BUSY_WAIT         in   1    memory busy; request complete on first cycle it is low after issue
// BEHAVIOUR
//  Address split: tag=[31:4+INDEX_BITS], index=[3+INDEX_BITS:4], word=[3:2], byte=[1:0].
//  Per line: valid, dirty, tag, 128-bit data. Storage uses flops, not memory macros.
//  Alignment: LW/SW ignore [1:0]; LH/LHU/SH ignore [0]. No misalignment trap.
//  Request = memReadEn[3] | memWriteEn[2]. If both are set, the store is performed and the load is ignored.
//  hit = valid & tag match & state==IDLE.
//  BUSY_WAIT is combinational: request & ~hit. It is 0 when there is no request.
//  Read hit: zero-latency. READ_DATA is combinational from the selected line in the same cycle, BUSY_WAIT=0.
//    LB/LH sign-extend. LBU/LHU zero-extend. Undefined funct3 returns 32'h0.
//  Write hit: byte/half/word merged into the line at posedge. dirty<=1. BUSY_WAIT=0.
//  READ_DATA=32'h0 when no load is active or on a miss.
//  FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
//  IDLE -> WRITEBACK: on a miss with the victim line valid & dirty.
//  IDLE -> FETCH: on a miss otherwise.
//  WRITEBACK: MEM_WRITE=1, MEM_ADDR={victim tag,index}, MEM_WRITE_DATA=victim data.
//    Goes to FETCH on the first cycle MEM_BUSY_WAIT=0 after entry.
//  FETCH: MEM_READ=1, MEM_ADDR=request[31:4].
//    Goes to UPDATE on the first cycle MEM_BUSY_WAIT=0 after entry.
//    In that cycle the line is written with MEM_READ_DATA, valid<=1, dirty<=0, tag<=request tag.
//  UPDATE: one cycle with BUSY_WAIT still 1, then IDLE.
//    The request now hits; a store hit then sets dirty.
//  MEM_READ and MEM_WRITE are never both 1. Both are 0 in IDLE and UPDATE.
//  Memory-side outputs are driven from state, not from MEM_BUSY_WAIT (no combinational path).
//  If the request drops mid-miss, the FSM completes the sequence anyway (line is allocated).
//  Reset (any time, including mid-miss):
//    all valid and dirty <= 0; state <= IDLE.
//    MEM_READ=MEM_WRITE=0, BUSY_WAIT=0 (absent request), READ_DATA=0.
//    Line data and tags are not reset.
// TESTING
//  Cold LW 0x0000_0040 with memory block = {4{32'hA5A5_0000+i}}:
//    FETCH issued, BUSY_WAIT high until UPDATE ends, then READ_DATA=word0.
//  SB 0x41 data 0x80, then LB 0x41 -> 32'hFFFF_FF80 and LBU 0x41 -> 32'h0000_0080.
//    Both hit, BUSY_WAIT=0 throughout.
//  Dirty eviction: SW 0x40=0xDEADBEEF, then LW 0x0000_00C0 (same index, INDEX_BITS=3):
//    MEM_WRITE with MEM_ADDR=28'h4 and [31:0]=DEADBEEF, then MEM_READ with MEM_ADDR=28'hC.
//  Memory latency sweep: MEM_BUSY_WAIT held 0, 1 and 5 cycles.
//    Miss completes after latency+2 cycles in FETCH/UPDATE; MEM_READ never glitches.
//  Assert RESET during FETCH: memory outputs drop asynchronously.
//    Re-issuing the same load misses again (valid cleared).
//  Simultaneous memReadEn=4'b1010 and memWriteEn=3'b110:
//    store performed, READ_DATA=0, later LW returns the stored word.

Source files
------------

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-back, write-allocate L1 data cache on the cpu data port.
//   Loads hit with zero latency. Stores hit and are merged at the clock edge.
//   A miss stalls the cpu through DATA_CACHE_BUSY_WAIT. The stall lasts while the
//   victim block is evicted (when it is dirty), the requested block is fetched,
//   and one update cycle completes.
//
// Ports
//   CLK, RESET            clock; asynchronous active-high reset
//   memReadEn[3:0]        [3] load enable, [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   memWriteEn[2:0]       [2] store enable, [1:0] size (SB/SH/SW)
//   DATA_CACHE_ADDR       cpu byte address
//   DATA_CACHE_DATA       store data
//   DATA_CACHE_READ_DATA  sign/zero-extended load result (0 when no load hit)
//   DATA_CACHE_BUSY_WAIT  stall request to the cpu (request & ~hit)
//   MEM_READ/MEM_WRITE    block read/write requests, decoded from state only
//   MEM_ADDR              block address (byte address [31:4])
//   MEM_WRITE_DATA        evicted block, word0 in [31:0]
//   MEM_READ_DATA         refill block, word0 in [31:0]
//   MEM_BUSY_WAIT         memory busy; a request completes on a cycle where it is low
module data_cache #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   memReadEn,
    input  logic [2:0]   memWriteEn,
    input  logic [31:0]  DATA_CACHE_ADDR,
    input  logic [31:0]  DATA_CACHE_DATA,
    output logic [31:0]  DATA_CACHE_READ_DATA,
    output logic         DATA_CACHE_BUSY_WAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDR,
    output logic [127:0] MEM_WRITE_DATA,
    input  logic [127:0] MEM_READ_DATA,
    input  logic         MEM_BUSY_WAIT
);

    localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS  = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    // Block address captured when the miss is detected. The refill and the
    // eviction then finish correctly even if the cpu drops its request
    // partway through the miss.
    logic [27:0]           miss_blk_q;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [1:0]            req_word;
    logic                  store_en;
    logic                  load_en;
    logic                  request;
    logic                  hit;
    logic                  write_hit;
    logic                  fill;

    logic [31:0] sel_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] merged_word;

    assign req_tag  = DATA_CACHE_ADDR[31:4+INDEX_BITS];
    assign req_idx  = DATA_CACHE_ADDR[3+INDEX_BITS:4];
    assign req_word = DATA_CACHE_ADDR[3:2];

    // A store takes priority. A load issued in the same cycle is ignored.
    assign store_en = memWriteEn[2];
    assign load_en  = memReadEn[3] & ~store_en;
    assign request  = memReadEn[3] | store_en;

    assign hit       = valid_q[req_idx] & (tag_q[req_idx] == req_tag) & (state_q == IDLE);
    assign write_hit = store_en & hit & (memWriteEn[1:0] != 2'b11);

    assign DATA_CACHE_BUSY_WAIT = request & ~hit;

    assign miss_idx = miss_blk_q[INDEX_BITS-1:0];
    assign miss_tag = miss_blk_q[27:INDEX_BITS];

    assign sel_word = data_q[req_idx][{req_word, 5'b0} +: 32];
    assign sel_byte = sel_word[{DATA_CACHE_ADDR[1:0], 3'b0} +: 8];
    assign sel_half = sel_word[{DATA_CACHE_ADDR[1], 4'b0} +: 16];

    // Load result extraction
    always_comb begin
        DATA_CACHE_READ_DATA = '0;
        if (load_en && hit) begin
            case (memReadEn[2:0])
                3'b000:  DATA_CACHE_READ_DATA = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  DATA_CACHE_READ_DATA = {{16{sel_half[15]}}, sel_half};
                3'b010:  DATA_CACHE_READ_DATA = sel_word;
                3'b100:  DATA_CACHE_READ_DATA = {24'h0, sel_byte};
                3'b101:  DATA_CACHE_READ_DATA = {16'h0, sel_half};
                default: DATA_CACHE_READ_DATA = '0;
            endcase
        end
    end

    // Store merge into the addressed word
    always_comb begin
        merged_word = sel_word;
        case (memWriteEn[1:0])
            2'b00:   merged_word[{DATA_CACHE_ADDR[1:0], 3'b0} +: 8] = DATA_CACHE_DATA[7:0];
            2'b01:   merged_word[{DATA_CACHE_ADDR[1], 4'b0} +: 16] = DATA_CACHE_DATA[15:0];
            2'b10:   merged_word = DATA_CACHE_DATA;
            default: merged_word = sel_word;
        endcase
    end

    // Miss FSM: the memory-side outputs decode from state alone
    always_comb begin
        state_d        = state_q;
        MEM_READ       = 1'b0;
        MEM_WRITE      = 1'b0;
        MEM_ADDR       = '0;
        MEM_WRITE_DATA = '0;
        fill           = 1'b0;
        case (state_q)
            IDLE: begin
                if (request && !hit) begin
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                MEM_WRITE      = 1'b1;
                MEM_ADDR       = {tag_q[miss_idx], miss_idx};
                MEM_WRITE_DATA = data_q[miss_idx];
                if (!MEM_BUSY_WAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                MEM_READ = 1'b1;
                MEM_ADDR = miss_blk_q;
                if (!MEM_BUSY_WAIT) begin
                    fill    = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            miss_blk_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && request && !hit) begin
                miss_blk_q <= DATA_CACHE_ADDR[31:4];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    // Line data and tags are not reset. The valid bits guard them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[miss_idx] <= MEM_READ_DATA;
            tag_q[miss_idx]  <= miss_tag;
        end else if (write_hit) begin
            data_q[req_idx][{req_word, 5'b0} +: 32] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Directed bench for data_cache. A behavioural block memory with a
//   programmable busy latency answers MEM_READ/MEM_WRITE. The memory also
//   records what requests it saw, so the bench can check eviction order,
//   addresses and refill timing.
module tb_data_cache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   memReadEn;
    logic [2:0]   memWriteEn;
    logic [31:0]  DATA_CACHE_ADDR;
    logic [31:0]  DATA_CACHE_DATA;
    logic [31:0]  DATA_CACHE_READ_DATA;
    logic         DATA_CACHE_BUSY_WAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] MEM_READ_DATA;
    logic         MEM_BUSY_WAIT = 1'b0;

    int n_checks = 0;
    int n_bad    = 0;

    data_cache #(.INDEX_BITS(3)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .memReadEn            (memReadEn),
        .memWriteEn           (memWriteEn),
        .DATA_CACHE_ADDR      (DATA_CACHE_ADDR),
        .DATA_CACHE_DATA      (DATA_CACHE_DATA),
        .DATA_CACHE_READ_DATA (DATA_CACHE_READ_DATA),
        .DATA_CACHE_BUSY_WAIT (DATA_CACHE_BUSY_WAIT),
        .MEM_READ             (MEM_READ),
        .MEM_WRITE            (MEM_WRITE),
        .MEM_ADDR             (MEM_ADDR),
        .MEM_WRITE_DATA       (MEM_WRITE_DATA),
        .MEM_READ_DATA        (MEM_READ_DATA),
        .MEM_BUSY_WAIT        (MEM_BUSY_WAIT)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural memory ----------------
    logic [127:0] mem [64];
    int           lat = 0;
    int           lat_cnt = 0;
    logic [1:0]   prev_req = 2'b00;
    logic [1:0]   cur_req;
    int           rd_rises, wr_rises, rd_cycles, rd_saw_wr;
    logic [27:0]  rd_addr_log, wr_addr_log;
    logic [127:0] wr_data_log;
    logic         both_seen = 1'b0;

    assign MEM_READ_DATA = mem[MEM_ADDR[5:0]];

    initial begin
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 4; i++) begin
                mem[b][i*32 +: 32] = {8'hB0, 8'(b), 16'(i)};
            end
        end
        for (int i = 0; i < 4; i++) begin
            mem[4][i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        end
    end

    always @(negedge CLK) begin
        cur_req = {MEM_READ, MEM_WRITE};
        if (MEM_READ && MEM_WRITE) both_seen = 1'b1;
        if (cur_req == 2'b00) begin
            lat_cnt       = 0;
            MEM_BUSY_WAIT = 1'b0;
        end else begin
            if (cur_req != prev_req) begin
                lat_cnt = 0;
                if (MEM_READ) begin
                    rd_rises++;
                    rd_saw_wr   = wr_rises;
                    rd_addr_log = MEM_ADDR;
                end else begin
                    wr_rises++;
                    wr_addr_log = MEM_ADDR;
                    wr_data_log = MEM_WRITE_DATA;
                end
            end
            MEM_BUSY_WAIT = (lat_cnt < lat);
            lat_cnt++;
            if (MEM_READ) rd_cycles++;
            if (MEM_WRITE && !MEM_BUSY_WAIT) mem[MEM_ADDR[5:0]] = MEM_WRITE_DATA;
        end
        prev_req = cur_req;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rd_rises    = 0;
        wr_rises    = 0;
        rd_cycles   = 0;
        rd_saw_wr   = 0;
        rd_addr_log = '0;
        wr_addr_log = '0;
        wr_data_log = '0;
    endtask

    // Starts at a falling edge. Holds the request until BUSY_WAIT drops,
    // captures READ_DATA in the hit cycle, lets one rising edge commit the
    // access, then releases the request at the next falling edge.
    task automatic access(input logic [3:0] re, input logic [2:0] we,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int cyc);
        memReadEn       = re;
        memWriteEn      = we;
        DATA_CACHE_ADDR = a;
        DATA_CACHE_DATA = d;
        cyc = 0;
        #1;
        if (DATA_CACHE_BUSY_WAIT) check("rdata_zero_on_miss", DATA_CACHE_READ_DATA, 32'h0);
        while (DATA_CACHE_BUSY_WAIT && cyc < 60) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        if (DATA_CACHE_BUSY_WAIT) check("busy_timeout", DATA_CACHE_BUSY_WAIT, 1'b0);
        rdata = DATA_CACHE_READ_DATA;
        @(negedge CLK);
        memReadEn  = '0;
        memWriteEn = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int          cyc;

        RESET           = 1'b1;
        memReadEn       = '0;
        memWriteEn      = '0;
        DATA_CACHE_ADDR = '0;
        DATA_CACHE_DATA = '0;
        @(negedge CLK);
        #1;
        check("rst_busy", DATA_CACHE_BUSY_WAIT, 1'b0);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_mem_write", MEM_WRITE, 1'b0);
        check("rst_rdata", DATA_CACHE_READ_DATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // Cold LW 0x40, latency 0: IDLE miss + FETCH + UPDATE = 3 stall cycles
        lat = 0;
        clear_log();
        access(4'b1010, 3'b000, 32'h40, 32'h0, rd, cyc);
        check("cold_lw_data", rd, 32'hA5A5_0000);
        check("cold_lw_busy", cyc, 3);
        check("cold_lw_rd_rises", rd_rises, 1);
        check("cold_lw_rd_cycles", rd_cycles, 1);
        check("cold_lw_rd_addr", rd_addr_log, 28'h4);
        check("cold_lw_no_wb", wr_rises, 0);

        // Byte/half hits on the resident line
        access(4'b0000, 3'b100, 32'h41, 32'h80, rd, cyc);
        check("sb_busy", cyc, 0);
        access(4'b1000, 3'b000, 32'h41, 32'h0, rd, cyc);
        check("lb_data", rd, 32'hFFFF_FF80);
        check("lb_busy", cyc, 0);
        access(4'b1100, 3'b000, 32'h41, 32'h0, rd, cyc);
        check("lbu_data", rd, 32'h0000_0080);
        check("lbu_busy", cyc, 0);
        access(4'b1001, 3'b000, 32'h42, 32'h0, rd, cyc);
        check("lh_hi_data", rd, 32'hFFFF_A5A5);
        access(4'b1001, 3'b000, 32'h40, 32'h0, rd, cyc);
        check("lh_lo_data", rd, 32'hFFFF_8000);
        access(4'b1101, 3'b000, 32'h41, 32'h0, rd, cyc);
        check("lhu_ignores_a0", rd, 32'h0000_8000);
        access(4'b1010, 3'b000, 32'h47, 32'h0, rd, cyc);
        check("lw_ignores_a10", rd, 32'hA5A5_0001);
        access(4'b1011, 3'b000, 32'h40, 32'h0, rd, cyc);
        check("undef_funct3", rd, 32'h0);

        // Dirty eviction: SW 0x40 then LW 0xC0 (same index), latency 1
        access(4'b0000, 3'b110, 32'h40, 32'hDEAD_BEEF, rd, cyc);
        check("sw_busy", cyc, 0);
        lat = 1;
        clear_log();
        access(4'b1010, 3'b000, 32'hC0, 32'h0, rd, cyc);
        check("evict_wr_rises", wr_rises, 1);
        check("evict_wr_addr", wr_addr_log, 28'h4);
        check("evict_wr_word0", wr_data_log[31:0], 32'hDEAD_BEEF);
        check("evict_wr_word1", wr_data_log[63:32], 32'hA5A5_0001);
        check("evict_rd_after_wr", rd_saw_wr, 1);
        check("evict_rd_addr", rd_addr_log, 28'hC);
        check("evict_data", rd, 32'hB00C_0000);
        check("evict_busy", cyc, 6);
        check("never_both", both_seen, 1'b0);

        // Latency sweep on cold lines: stall = latency + 3
        lat = 5;
        clear_log();
        access(4'b1010, 3'b000, 32'h100, 32'h0, rd, cyc);
        check("lat5_busy", cyc, 8);
        check("lat5_rd_cycles", rd_cycles, 6);
        check("lat5_rd_rises", rd_rises, 1);
        check("lat5_data", rd, 32'hB010_0000);
        lat = 1;
        clear_log();
        access(4'b1010, 3'b000, 32'h118, 32'h0, rd, cyc);
        check("lat1_busy", cyc, 4);
        check("lat1_rd_cycles", rd_cycles, 2);
        check("lat1_rd_rises", rd_rises, 1);
        check("lat1_data", rd, 32'hB011_0002);

        // The clean line at index 4 is replaced without a writeback, and the
        // data fetched back shows that the earlier eviction reached memory
        lat = 0;
        clear_log();
        access(4'b1010, 3'b000, 32'h40, 32'h0, rd, cyc);
        check("reload_no_wb", wr_rises, 0);
        check("reload_busy", cyc, 3);
        check("reload_data", rd, 32'hDEAD_BEEF);

        // Reset asserted during FETCH
        lat = 5;
        clear_log();
        memReadEn       = 4'b1010;
        memWriteEn      = 3'b000;
        DATA_CACHE_ADDR = 32'h200;
        @(negedge CLK);
        #1;
        check("mid_fetch_read", MEM_READ, 1'b1);
        check("mid_fetch_addr", MEM_ADDR, 28'h20);
        #1;
        RESET = 1'b1;
        #1;
        check("async_rst_mem_read", MEM_READ, 1'b0);
        check("async_rst_mem_write", MEM_WRITE, 1'b0);
        memReadEn = '0;
        #1;
        check("async_rst_busy", DATA_CACHE_BUSY_WAIT, 1'b0);
        check("async_rst_rdata", DATA_CACHE_READ_DATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        lat = 0;
        access(4'b1010, 3'b000, 32'h200, 32'h0, rd, cyc);
        check("post_rst_miss_busy", cyc, 3);
        check("post_rst_miss_data", rd, 32'hB020_0000);
        access(4'b1010, 3'b000, 32'h40, 32'h0, rd, cyc);
        check("post_rst_valid_cleared", cyc, 3);
        check("post_rst_data", rd, 32'hDEAD_BEEF);

        // Load and store together: only the store takes effect
        access(4'b1010, 3'b110, 32'h40, 32'h1234_5678, rd, cyc);
        check("ld_st_rdata", rd, 32'h0);
        check("ld_st_busy", cyc, 0);
        access(4'b1010, 3'b000, 32'h40, 32'h0, rd, cyc);
        check("ld_st_stored", rd, 32'h1234_5678);

        // Half store into the upper half of word 1
        access(4'b0000, 3'b101, 32'h46, 32'h0000_BEEF, rd, cyc);
        access(4'b1010, 3'b000, 32'h44, 32'h0, rd, cyc);
        check("sh_merge", rd, 32'hBEEF_0001);
        check("never_both_end", both_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
